ca_stream_protocol_monitor: RTL and testbench

CA_STREAM_PROTOCOL_MONITOR -- requirements
Module: ca_stream_protocol_monitor

---
 rtl/ca_monitor_pkg.sv | 50 +++++
 rtl/ca_stream_protocol_monitor_if.sv | 28 ++
 rtl/ca_monitor_track_fifo.sv | 68 ++++++
 rtl/ca_stream_protocol_monitor.sv | 162 ++++++++++++++++
 tb/tb_ca_stream_protocol_monitor.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/ca_monitor_pkg.sv
// Shared definitions for the stream protocol monitor: word field positions,
// fault bit indices, length-mode encodings and the tracked entry layout.
package ca_monitor_pkg;

    localparam int unsigned WORD_W  = 64;
    localparam int unsigned FAULT_W = 16;
    localparam int unsigned LEN_HI  = 63;
    localparam int unsigned LEN_LO  = 48;
    localparam int unsigned SOF_BIT = 31;
    localparam int unsigned EOF_BIT = 30;
    localparam int unsigned CH_HI   = 15;
    localparam int unsigned CH_LO   = 0;

    typedef enum int unsigned {
        FLT_CH_MISMATCH  = 0,
        FLT_LEN_GT       = 1,
        FLT_SOF_MISMATCH = 2,
        FLT_EOF_MISMATCH = 3,
        FLT_REQ_UFLOW    = 4,
        FLT_RESP_UFLOW   = 5,
        FLT_REQ_OFLOW    = 6,
        FLT_RESP_OFLOW   = 7,
        FLT_LEN_MAX      = 8,
        FLT_LEN_ZERO     = 9,
        FLT_LEN_NE       = 10,
        FLT_CH_RANGE     = 11
    } fault_bit_e;

    typedef enum int unsigned {
        LEN_MODE_LE = 0,
        LEN_MODE_EQ = 1
    } len_mode_e;

    typedef struct packed {
        logic [15:0] channel;
        logic        sof;
        logic        eof;
        logic [15:0] len;
    } track_word_t;

    function automatic track_word_t decode_word(input logic [WORD_W-1:0] w);
        track_word_t d;
        d.channel = w[CH_HI:CH_LO];
        d.sof     = w[SOF_BIT];
        d.eof     = w[EOF_BIT];
        d.len     = w[LEN_HI:LEN_LO];
        return d;
    endfunction

endpackage

// File: rtl/ca_stream_protocol_monitor_if.sv
// Request/response/data stream bundle observed by the protocol monitor.
interface ca_stream_protocol_monitor_if
    import ca_monitor_pkg::*;
#(
    parameter int unsigned DATA_W = 32
);
    logic              req_tvalid;
    logic              req_tready;
    logic [WORD_W-1:0] req_tdata;
    logic              resp_tvalid;
    logic              resp_tready;
    logic [WORD_W-1:0] resp_tdata;
    logic              data_tvalid;
    logic              data_tready;
    logic [DATA_W-1:0] data_tdata;

    modport master (
        output req_tvalid, req_tready, req_tdata,
        output resp_tvalid, resp_tready, resp_tdata,
        output data_tvalid, data_tready, data_tdata
    );

    modport slave (
        input req_tvalid, req_tready, req_tdata,
        input resp_tvalid, resp_tready, resp_tdata,
        input data_tvalid, data_tready, data_tdata
    );
endinterface

// File: rtl/ca_monitor_track_fifo.sv
// Tracking FIFO: push is dropped when full unless a pop happens in the same
// cycle; pop on empty is ignored. Occupancy ranges 0..DEPTH.
module ca_monitor_track_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned   AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_FULL) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ca_stream_protocol_monitor.sv
// Passive checker for a req/resp/data stream protocol: tracks outstanding
// requests and expected data beats, and reports per-cycle and sticky faults.
module ca_stream_protocol_monitor
    import ca_monitor_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_BURST  = 16'h1000,
    parameter int unsigned REQ_DEPTH  = 8,
    parameter int unsigned RESP_DEPTH = 8,
    parameter int unsigned NUM_CH     = 32,
    parameter int unsigned LEN_MODE   = 0
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    ca_stream_protocol_monitor_if.slave  bus,
    input  logic                         err_clear,
    output logic [FAULT_W-1:0]           protocol_error,
    output logic                         protocol_error_ap_vld,
    output logic [FAULT_W-1:0]           error_sticky,
    output logic [15:0]                  error_count
);
    localparam int unsigned BYTES       = DATA_W / 8;
    localparam logic [16:0] MAX_BURST_W = 17'(MAX_BURST);
    localparam logic [16:0] NUM_CH_W    = 17'(NUM_CH);
    localparam logic [16:0] BYTES_W     = 17'(BYTES);
    localparam logic [16:0] BYTES_M1_W  = 17'(BYTES - 1);
    localparam int unsigned ENTRY_W     = $bits(track_word_t);

    logic              req_hs, resp_hs, data_hs;
    track_word_t       req_word, resp_word, req_head;
    logic              req_full, req_empty, req_pop;
    logic              resp_full, resp_empty, resp_push, resp_pop;
    logic [15:0]       resp_beats, resp_head, data_remaining;
    logic [15:0]       data_cnt_q, data_cnt_d;
    logic [FAULT_W-1:0] fault_now;

    logic [FAULT_W-1:0] protocol_error_q, protocol_error_d;
    logic               error_vld_q, error_vld_d;
    logic [FAULT_W-1:0] error_sticky_q, error_sticky_d;
    logic [15:0]        error_count_q, error_count_d;

    logic unused_data;
    assign unused_data = ^bus.data_tdata;

    always_comb begin
        req_hs     = bus.req_tvalid && bus.req_tready;
        resp_hs    = bus.resp_tvalid && bus.resp_tready;
        data_hs    = bus.data_tvalid && bus.data_tready;
        req_word   = decode_word(bus.req_tdata);
        resp_word  = decode_word(bus.resp_tdata);
        req_pop    = resp_hs && !req_empty;
        resp_push  = resp_hs && (resp_word.len != '0);
        resp_beats = 16'(({1'b0, resp_word.len} + BYTES_M1_W) / BYTES_W);
    end

    ca_monitor_track_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(REQ_DEPTH)
    ) u_req_fifo (
        .clk  (ap_clk),
        .rst  (ap_rst),
        .push (req_hs),
        .pop  (req_pop),
        .din  (req_word),
        .full (req_full),
        .empty(req_empty),
        .head (req_head)
    );

    ca_monitor_track_fifo #(
        .WIDTH(16),
        .DEPTH(RESP_DEPTH)
    ) u_resp_fifo (
        .clk  (ap_clk),
        .rst  (ap_rst),
        .push (resp_push),
        .pop  (resp_pop),
        .din  (resp_beats),
        .full (resp_full),
        .empty(resp_empty),
        .head (resp_head)
    );

    // A zero counter means "not yet loaded": the head is never zero because
    // zero-length responses push nothing.
    always_comb begin
        data_remaining = (data_cnt_q == '0) ? resp_head : data_cnt_q;
        data_cnt_d     = data_cnt_q;
        resp_pop       = 1'b0;
        if (data_hs && !resp_empty) begin
            if (data_remaining == 16'd1) begin
                resp_pop   = 1'b1;
                data_cnt_d = '0;
            end else begin
                data_cnt_d = data_remaining - 16'd1;
            end
        end
    end

    always_comb begin
        fault_now = '0;
        if (req_hs) begin
            fault_now[FLT_REQ_OFLOW] = req_full && !req_pop;
            fault_now[FLT_LEN_MAX]   = {1'b0, req_word.len} > MAX_BURST_W;
            fault_now[FLT_LEN_ZERO]  = (req_word.len == '0);
            if ({1'b0, req_word.channel} >= NUM_CH_W) begin
                fault_now[FLT_CH_RANGE] = 1'b1;
            end
        end
        if (resp_hs) begin
            if (req_empty) begin
                fault_now[FLT_REQ_UFLOW] = 1'b1;
            end else begin
                fault_now[FLT_CH_MISMATCH]  = (resp_word.channel != req_head.channel);
                fault_now[FLT_LEN_GT]       = (resp_word.len > req_head.len);
                fault_now[FLT_SOF_MISMATCH] = (resp_word.sof != req_head.sof);
                fault_now[FLT_EOF_MISMATCH] = (resp_word.eof != req_head.eof);
                fault_now[FLT_LEN_NE]       = (LEN_MODE == LEN_MODE_EQ) &&
                                              (resp_word.len != req_head.len);
            end
            if ({1'b0, resp_word.channel} >= NUM_CH_W) begin
                fault_now[FLT_CH_RANGE] = 1'b1;
            end
        end
        fault_now[FLT_RESP_OFLOW] = resp_push && resp_full && !resp_pop;
        fault_now[FLT_RESP_UFLOW] = data_hs && resp_empty;
    end

    always_comb begin
        protocol_error_d = fault_now;
        error_vld_d      = |fault_now;
        error_sticky_d   = err_clear ? fault_now : (error_sticky_q | fault_now);
        error_count_d    = error_count_q;
        if (err_clear) begin
            error_count_d = {15'd0, |fault_now};
        end else if ((|fault_now) && (error_count_q != 16'hFFFF)) begin
            error_count_d = error_count_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            data_cnt_q       <= '0;
            protocol_error_q <= '0;
            error_vld_q      <= 1'b0;
            error_sticky_q   <= '0;
            error_count_q    <= '0;
        end else begin
            data_cnt_q       <= data_cnt_d;
            protocol_error_q <= protocol_error_d;
            error_vld_q      <= error_vld_d;
            error_sticky_q   <= error_sticky_d;
            error_count_q    <= error_count_d;
        end
    end

    assign protocol_error        = protocol_error_q;
    assign protocol_error_ap_vld = error_vld_q;
    assign error_sticky          = error_sticky_q;
    assign error_count           = error_count_q;

endmodule

// File: tb/tb_ca_stream_protocol_monitor.sv
// Directed bench for ca_stream_protocol_monitor: two instances share one bus,
// one with LEN_MODE=0 and one with LEN_MODE=1.
module tb_ca_stream_protocol_monitor;

    logic ap_clk = 1'b0;
    logic ap_rst;
    logic err_clear;
    logic rdy = 1'b1;

    logic [15:0] pe0, st0, cnt0, pe1, st1, cnt1;
    logic        vld0, vld1;

    ca_stream_protocol_monitor_if #(.DATA_W(32)) bus ();

    ca_stream_protocol_monitor #(
        .DATA_W(32), .MAX_BURST(16'h1000), .REQ_DEPTH(8), .RESP_DEPTH(8),
        .NUM_CH(32), .LEN_MODE(0)
    ) dut0 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus), .err_clear(err_clear),
        .protocol_error(pe0), .protocol_error_ap_vld(vld0),
        .error_sticky(st0), .error_count(cnt0)
    );

    ca_stream_protocol_monitor #(
        .DATA_W(32), .MAX_BURST(16'h1000), .REQ_DEPTH(8), .RESP_DEPTH(8),
        .NUM_CH(32), .LEN_MODE(1)
    ) dut1 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus), .err_clear(err_clear),
        .protocol_error(pe1), .protocol_error_ap_vld(vld1),
        .error_sticky(st1), .error_count(cnt1)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        string       tag;
        logic [15:0] e0;
        logic [15:0] e1;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] ch, input logic [15:0] len,
                                       input logic sof, input logic eof);
        return {len, 16'h0000, sof, eof, 14'h0000, ch};
    endfunction

    task automatic drive_idle();
        bus.req_tvalid  = 1'b0;
        bus.req_tready  = 1'b0;
        bus.req_tdata   = '0;
        bus.resp_tvalid = 1'b0;
        bus.resp_tready = 1'b0;
        bus.resp_tdata  = '0;
        bus.data_tvalid = 1'b0;
        bus.data_tready = 1'b0;
        bus.data_tdata  = '0;
        err_clear       = 1'b0;
    endtask

    // One clock of stimulus; expected vectors are queued on drive and
    // compared against the registered outputs just after the edge.
    task automatic cyc(input string tag, input logic rq_v, input logic [63:0] rq,
                       input logic rs_v, input logic [63:0] rs, input logic d_v,
                       input logic clr, input logic [15:0] e0, input logic [15:0] e1);
        exp_t e;
        @(negedge ap_clk);
        bus.req_tvalid  = rq_v;
        bus.req_tready  = rdy;
        bus.req_tdata   = rq;
        bus.resp_tvalid = rs_v;
        bus.resp_tready = rdy;
        bus.resp_tdata  = rs;
        bus.data_tvalid = d_v;
        bus.data_tready = rdy;
        bus.data_tdata  = $urandom;
        err_clear       = clr;
        e.tag = tag;
        e.e0  = e0;
        e.e1  = e1;
        sb.push_back(e);
        @(posedge ap_clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".err0"}, pe0, e.e0);
        chk({e.tag, ".vld0"}, {15'd0, vld0}, {15'd0, |e.e0});
        chk({e.tag, ".err1"}, pe1, e.e1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge ap_clk);
        drive_idle();
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        chk({tag, ".err0"}, pe0, 16'h0000);
        chk({tag, ".vld0"}, {15'd0, vld0}, 16'h0000);
        chk({tag, ".sticky0"}, st0, 16'h0000);
        chk({tag, ".count0"}, cnt0, 16'h0000);
        chk({tag, ".err1"}, pe1, 16'h0000);
        chk({tag, ".vld1"}, {15'd0, vld1}, 16'h0000);
        chk({tag, ".sticky1"}, st1, 16'h0000);
        chk({tag, ".count1"}, cnt1, 16'h0000);
        sb.delete();
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        ap_rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge ap_clk);
        do_reset("por");

        // nominal burst, then both FIFOs shown empty by underflow faults
        cyc("nom_req", 1, mk(3, 64, 1, 1), 0, '0, 0, 0, 16'h0000, 16'h0000);
        cyc("nom_resp", 0, '0, 1, mk(3, 64, 1, 1), 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 16; i++) cyc("nom_data", 0, '0, 0, '0, 1, 0, 16'h0000, 16'h0000);
        cyc("data_uflow", 0, '0, 0, '0, 1, 0, 16'h0020, 16'h0020);
        cyc("resp_uflow", 0, '0, 1, mk(3, 0, 1, 1), 0, 0, 16'h0010, 16'h0010);
        chk("sticky_acc", st0, 16'h0030);
        chk("count_acc", cnt0, 16'd2);
        cyc("clear", 0, '0, 0, '0, 0, 1, 16'h0000, 16'h0000);
        chk("sticky_clr", st0, 16'h0000);
        chk("count_clr", cnt0, 16'd0);

        // valid without ready is not a handshake
        rdy = 1'b0;
        cyc("no_hs", 1, mk(3, 0, 1, 1), 1, mk(3, 0, 1, 1), 1, 0, 16'h0000, 16'h0000);
        rdy = 1'b1;

        // length rules
        cyc("len_req", 1, mk(3, 64, 1, 1), 0, '0, 0, 0, 16'h0000, 16'h0000);
        cyc("len_long", 0, '0, 1, mk(3, 128, 1, 1), 0, 0, 16'h0002, 16'h0402);
        cyc("len_vld_low", 0, '0, 0, '0, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 32; i++) cyc("len_drain", 0, '0, 0, '0, 1, 0, 16'h0000, 16'h0000);
        cyc("len_req2", 1, mk(3, 64, 1, 1), 0, '0, 0, 0, 16'h0000, 16'h0000);
        cyc("len_short", 0, '0, 1, mk(3, 32, 1, 1), 0, 0, 16'h0000, 16'h0400);
        for (int i = 0; i < 8; i++) cyc("short_drain", 0, '0, 0, '0, 1, 0, 16'h0000, 16'h0000);

        // field mismatches and response channel range
        cyc("mm_req", 1, mk(5, 64, 1, 0), 0, '0, 0, 0, 16'h0000, 16'h0000);
        cyc("mm_resp", 0, '0, 1, mk(6, 0, 0, 1), 0, 0, 16'h000D, 16'h040D);
        cyc("rch_req", 1, mk(3, 8, 1, 1), 0, '0, 0, 0, 16'h0000, 16'h0000);
        cyc("rch_resp", 0, '0, 1, mk(40, 8, 1, 1), 0, 0, 16'h0801, 16'h0801);
        for (int i = 0; i < 2; i++) cyc("rch_drain", 0, '0, 0, '0, 1, 0, 16'h0000, 16'h0000);
        cyc("rch_empty", 0, '0, 0, '0, 1, 0, 16'h0020, 16'h0020);

        // request checks at and past their limits
        cyc("req_len0", 1, mk(3, 0, 1, 1), 0, '0, 0, 0, 16'h0200, 16'h0200);
        cyc("req_max", 1, mk(3, 16'h1000, 1, 1), 0, '0, 0, 0, 16'h0000, 16'h0000);
        cyc("req_over", 1, mk(3, 16'h1001, 1, 1), 0, '0, 0, 0, 16'h0100, 16'h0100);
        cyc("req_ch_last", 1, mk(31, 64, 1, 1), 0, '0, 0, 0, 16'h0000, 16'h0000);
        cyc("req_ch_range", 1, mk(32, 64, 1, 1), 0, '0, 0, 0, 16'h0800, 16'h0800);
        do_reset("rst_a");

        // request FIFO full, overflow, push+pop at full
        for (int i = 0; i < 8; i++) cyc("fill", 1, mk(1, 16, 1, 1), 0, '0, 0, 0, 16'h0000, 16'h0000);
        cyc("req_ovfl", 1, mk(1, 16, 1, 1), 0, '0, 0, 0, 16'h0040, 16'h0040);
        cyc("full_pp", 1, mk(1, 16, 1, 1), 1, mk(1, 16, 1, 1), 0, 0, 16'h0000, 16'h0000);
        cyc("still_full", 1, mk(1, 16, 1, 1), 0, '0, 0, 0, 16'h0040, 16'h0040);
        for (int i = 0; i < 7; i++) cyc("resp_fill", 0, '0, 1, mk(1, 16, 1, 1), 0, 0, 16'h0000, 16'h0000);
        cyc("resp_ovfl", 0, '0, 1, mk(1, 16, 1, 1), 0, 0, 16'h0080, 16'h0080);
        cyc("rpp_req", 1, mk(1, 16, 1, 1), 0, '0, 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) cyc("rpp_data", 0, '0, 0, '0, 1, 0, 16'h0000, 16'h0000);
        cyc("resp_full_pp", 0, '0, 1, mk(1, 16, 1, 1), 1, 0, 16'h0000, 16'h0000);
        do_reset("rst_b");

        // clear coinciding with a new fault
        cyc("stk_req0", 1, mk(3, 0, 1, 1), 0, '0, 0, 0, 16'h0200, 16'h0200);
        cyc("stk_clr", 0, '0, 1, mk(4, 0, 1, 1), 0, 1, 16'h0001, 16'h0001);
        chk("stk_sticky", st0, 16'h0001);
        chk("stk_count", cnt0, 16'd1);
        cyc("stk_more", 0, '0, 0, '0, 1, 0, 16'h0020, 16'h0020);
        chk("stk_sticky2", st0, 16'h0021);
        chk("stk_count2", cnt0, 16'd2);

        // reset in the middle of a burst discards tracked state
        cyc("mb_req", 1, mk(3, 64, 1, 1), 0, '0, 0, 0, 16'h0000, 16'h0000);
        cyc("mb_resp", 0, '0, 1, mk(3, 64, 1, 1), 0, 0, 16'h0000, 16'h0000);
        for (int i = 0; i < 5; i++) cyc("mb_data", 0, '0, 0, '0, 1, 0, 16'h0000, 16'h0000);
        cyc("mb_fault", 1, mk(3, 0, 1, 1), 0, '0, 0, 0, 16'h0200, 16'h0200);
        do_reset("rst_mid");
        cyc("post_data", 0, '0, 0, '0, 1, 0, 16'h0020, 16'h0020);
        cyc("post_resp", 0, '0, 1, mk(3, 0, 1, 1), 0, 0, 16'h0010, 16'h0010);
        chk("post_count", cnt0, 16'd2);

        @(negedge ap_clk);
        drive_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
